// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU bus (m0) and the loader/IO master (m1).
// Define MEM_TIMEOUT_EN to abort BUSY transactions after TIMEOUT_CYCLES cycles with no mem_ready.
module mem_arbiter #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_w_q, mem_w_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic              win;

`ifdef MEM_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_w_d     = mem_w_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        error_d     = error_q;
`endif
        // Under contention the requester that did not win last time goes first.
        win = (m0_req && m1_req) ? ~owner_q : m1_req;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d     = win;
                    mem_req_d   = 1'b1;
                    mem_w_d     = win ? m1_we    : m0_we;
                    mem_addr_d  = win ? m1_addr  : m0_addr;
                    mem_wdata_d = win ? m1_wdata : m0_wdata;
                    state_d     = BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_req_d  = 1'b0;
                    mem_w_d    = 1'b0;
                    if (!mem_w_q) rdata_d = mem_rdata;
                    m0_ready_d = ~owner_q;
                    m1_ready_d = owner_q;
                    state_d    = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    mem_req_d  = 1'b0;
                    mem_w_d    = 1'b0;
                    rdata_d    = '0;
                    error_d    = 1'b1;
                    m0_ready_d = ~owner_q;
                    m1_ready_d = owner_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_w_q     <= mem_w_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            m0_ready_q  <= m0_ready_d;
            m1_ready_q  <= m1_ready_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            error_q     <= error_d;
`endif
        end
    end

    assign owner     = owner_q;
    assign mem_req   = mem_req_q;
    assign mem_w     = mem_w_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign m0_ready  = m0_ready_q;
    assign m1_ready  = m1_ready_q;
`ifdef MEM_TIMEOUT_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule
